// File: rtl/tsc_pkg.sv
// Shared types and default sizing for the triggered sample-capture controller.
package tsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_POST,
    ST_FULL
  } state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_DROP
  } hs_t;

  localparam int DEF_DEPTH = 32;
  localparam int DEF_AW    = 5;
  localparam int DEF_POST  = 16;
  localparam int DEF_TS_W  = 32;

endpackage

// File: rtl/tsc_adc_hs.sv
// ADC req/rdy handshake: rdy double-flop synchroniser, handshake FSM and sample hand-off.
module tsc_adc_hs
  import tsc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       adc_rdy,
  input  logic [7:0] adc_dat,
  output logic       adc_req,
  output logic       smp_vld,
  output logic [7:0] smp_dat,
  output logic       idle
);

  logic rdy_s1;
  logic rdy_s2;
  hs_t  hs;
  hs_t  hs_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_s1 <= 1'b0;
      rdy_s2 <= 1'b0;
      hs     <= HS_IDLE;
    end else begin
      rdy_s1 <= adc_rdy;
      rdy_s2 <= rdy_s1;
      hs     <= hs_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hs_nxt  = hs;
    smp_vld = 1'b0;
    unique case (hs)
      HS_IDLE: if (go && !rdy_s2) hs_nxt = HS_REQ;
      HS_REQ: begin
        if (rdy_s2) begin
          smp_vld = 1'b1;
          hs_nxt  = HS_DROP;
        end
      end
      HS_DROP: if (!rdy_s2) hs_nxt = HS_IDLE;
      default: hs_nxt = HS_IDLE;
    endcase
  end

  // adc_dat is held stable by the ADC while rdy is high, so it is captured directly on smp_vld.
  assign smp_dat = adc_dat;
  assign adc_req = (hs == HS_REQ);
  assign idle    = (hs == HS_IDLE);

endmodule

// File: rtl/tsc_capture.sv
// Triggered capture: circular pre-trigger buffer, timestamped threshold crossing, oldest-first readout.
module tsc_capture
  import tsc_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int POST  = DEF_POST,
  parameter int TS_W  = DEF_TS_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      trig_lvl,
  output logic            adc_rst,
  output logic            adc_req,
  input  logic            adc_rdy,
  input  logic [7:0]      adc_dat,
  output logic            busy,
  output logic            sbf,
  output logic [TS_W-1:0] trig_ts,
  input  logic            rd_en,
  output logic [7:0]      rd_dat,
  output logic            rd_vld,
  output logic            rd_last
);

  localparam logic [AW:0] POST_N  = POST[AW:0];
  localparam logic [AW:0] DEPTH_N = DEPTH[AW:0];
  localparam logic [AW:0] LAST_N  = DEPTH_N - 1'b1;

  state_t            state;
  state_t            state_nxt;
  logic [TS_W-1:0]   ts;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       post_cnt;
  logic [AW:0]       rd_cnt;
  logic [DEPTH-1:0]  vld;
  logic [7:0]        mem [DEPTH];
  logic [7:0]        prev;
  logic              prev_ok;
  logic              go;
  logic              smp_vld;
  logic [7:0]        smp_dat;
  logic              hs_idle;
  logic              trig_hit;
  logic              post_done;
  logic              wr_en;

  tsc_adc_hs u_hs (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
    .adc_rdy (adc_rdy),
    .adc_dat (adc_dat),
    .adc_req (adc_req),
    .smp_vld (smp_vld),
    .smp_dat (smp_dat),
    .idle    (hs_idle)
  );

  // trig_lvl = 0 can never fire: prev < 0 is impossible for an unsigned compare.
  assign trig_hit  = prev_ok && (prev < trig_lvl) && (smp_dat >= trig_lvl);
  assign post_done = (post_cnt == POST_N);
  assign busy      = (state == ST_ARMED) || (state == ST_POST);
  assign sbf       = (state == ST_FULL);
  assign wr_en     = rst_n && smp_vld && busy;

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_ARMED;
      ST_ARMED: begin
        go = 1'b1;
        if (smp_vld && trig_hit) state_nxt = ST_POST;
      end
      ST_POST: begin
        go = !post_done;
        // Leave only once the last handshake has fully released (sync rdy back low).
        if (post_done && hs_idle) state_nxt = ST_FULL;
      end
      ST_FULL:  if (rd_cnt == DEPTH_N) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      adc_rst  <= 1'b1;
      ts       <= '0;
      trig_ts  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      post_cnt <= '0;
      rd_cnt   <= '0;
      vld      <= '0;
      prev     <= '0;
      prev_ok  <= 1'b0;
      rd_dat   <= '0;
      rd_vld   <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      state   <= state_nxt;
      adc_rst <= 1'b0;
      ts      <= ts + 1'b1;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            wr_ptr  <= '0;
            vld     <= '0;
            prev_ok <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (smp_vld) begin
            prev    <= smp_dat;
            prev_ok <= 1'b1;
            if (trig_hit) begin
              trig_ts  <= ts;
              post_cnt <= 1;
            end
          end
        end
        ST_POST: begin
          if (smp_vld) post_cnt <= post_cnt + 1'b1;
          if (state_nxt == ST_FULL) begin
            rd_ptr <= wr_ptr;
            rd_cnt <= '0;
          end
        end
        ST_FULL: begin
          if (rd_en && (rd_cnt != DEPTH_N)) begin
            rd_dat  <= vld[rd_ptr] ? mem[rd_ptr] : 8'h00;
            rd_vld  <= 1'b1;
            rd_last <= (rd_cnt == LAST_N);
            rd_ptr  <= rd_ptr + 1'b1;
            rd_cnt  <= rd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
      if (wr_en) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
    end
  end

  // NOTE: sample storage is not reset; the valid bits mask stale entries on readout.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= smp_dat;
  end

endmodule

// File: tb/tb_tsc_capture.sv
// Directed bench for tsc_capture with a behavioural ADC handshake model.
module tb_tsc_capture;

  localparam int DEPTH = 32;
  localparam int POST  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  trig_lvl = 8'd0;
  logic        adc_rst;
  logic        adc_req;
  logic        adc_rdy = 1'b0;
  logic [7:0]  adc_dat = 8'd0;
  logic        busy;
  logic        sbf;
  logic [31:0] trig_ts;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_dat;
  logic        rd_vld;
  logic        rd_last;

  always #5 clk = ~clk;

  tsc_capture #(.DEPTH(DEPTH), .AW(5), .POST(POST), .TS_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .trig_lvl (trig_lvl),
    .adc_rst  (adc_rst),
    .adc_req  (adc_req),
    .adc_rdy  (adc_rdy),
    .adc_dat  (adc_dat),
    .busy     (busy),
    .sbf      (sbf),
    .trig_ts  (trig_ts),
    .rd_en    (rd_en),
    .rd_dat   (rd_dat),
    .rd_vld   (rd_vld),
    .rd_last  (rd_last)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference cycle count: equals the number of clk edges since reset released.
  logic [31:0] cyc;
  always @(posedge clk) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 1;
  end

  // ADC model: answers each req with the next sample, logs the timestamp of each latch edge.
  logic [7:0]  samples [256];
  logic [31:0] lat_ts  [256];
  int idx;
  int m_st;
  always @(negedge clk) begin
    if (!rst_n) begin
      adc_rdy = 1'b0;
      m_st    = 0;
      idx     = 0;
    end else if (m_st == 0) begin
      if (adc_req) begin
        adc_dat = samples[idx & 255];
        adc_rdy = 1'b1;
        m_st    = 1;
      end
    end else if (!adc_req) begin
      adc_rdy = 1'b0;
      lat_ts[idx & 255] = cyc - 1;
      idx++;
      m_st = 0;
    end
  end

  typedef struct {
    string      name;
    logic [7:0] lvl;
    int         kind;
    int         trig_idx;
  } scen_t;

  task automatic fill(input int kind);
    for (int i = 0; i < 256; i++) begin
      case (kind)
        0: samples[i] = 8'(i);
        1: begin
          case (i)
            0: samples[i] = 8'd5;
            1: samples[i] = 8'd20;
            2: samples[i] = 8'd20;
            3: samples[i] = 8'd3;
            4: samples[i] = 8'd12;
            default: samples[i] = 8'(30 + i);
          endcase
        end
        default: begin
          if (i < 100)       samples[i] = 8'((i * 7) % 50);
          else if (i == 100) samples[i] = 8'd250;
          else               samples[i] = 8'(i);
        end
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_scen(input scen_t s, input bit poke_full);
    int nwr;
    int k;
    logic [7:0] exp;
    fill(s.kind);
    do_reset();
    trig_lvl = s.lvl;
    pulse_start();
    check({s.name, "_busy"}, 32'(busy), 32'd1);
    for (int c = 0; c < 5000 && !sbf; c++) @(negedge clk);
    check({s.name, "_sbf_set"}, 32'(sbf), 32'd1);
    if (!sbf) return;
    nwr = s.trig_idx + POST;
    check({s.name, "_busy_full"}, 32'(busy), 32'd0);
    check({s.name, "_trig_ts"}, trig_ts, lat_ts[s.trig_idx]);
    check({s.name, "_n_samples"}, 32'(idx), 32'(nwr));
    if (poke_full) begin
      pulse_start();
      check({s.name, "_start_in_full"}, 32'({sbf, busy}), 32'b10);
    end
    for (int i = 0; i < DEPTH; i++) begin
      k   = nwr - DEPTH + i;
      exp = (k < 0) ? 8'h00 : samples[k];
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      check($sformatf("%s_rd%0d_vld", s.name, i), 32'(rd_vld), 32'd1);
      check($sformatf("%s_rd%0d_dat", s.name, i), 32'(rd_dat), 32'(exp));
      check($sformatf("%s_rd%0d_last", s.name, i), 32'(rd_last), 32'(i == DEPTH - 1));
      if (i == DEPTH - 1) check({s.name, "_sbf_on_last"}, 32'(sbf), 32'd1);
      @(negedge clk);
    end
    check({s.name, "_sbf_clear"}, 32'(sbf), 32'd0);
  endtask

  scen_t tbl [3];

  initial begin
    tbl[0] = '{name: "ramp",  lvl: 8'd10,  kind: 0, trig_idx: 10};
    tbl[1] = '{name: "seq",   lvl: 8'd12,  kind: 1, trig_idx: 1};
    tbl[2] = '{name: "wrap",  lvl: 8'd200, kind: 2, trig_idx: 100};
    fill(0);

    // Reset state held for three cycles, then release.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_adc_rst", 32'(adc_rst), 32'd1);
    check("rst_outputs", 32'({adc_req, busy, sbf, rd_vld, rd_last}), 32'd0);
    check("rst_rd_dat", 32'(rd_dat), 32'd0);
    check("rst_trig_ts", trig_ts, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_adc_rst", 32'(adc_rst), 32'd0);

    for (int t = 0; t < 3; t++) run_scen(tbl[t], t == 0);

    // trig_lvl = 0 never triggers; rd_en while armed is ignored; reset mid-handshake.
    fill(0);
    do_reset();
    trig_lvl = 8'd0;
    pulse_start();
    for (int c = 0; c < 2000 && idx < 40; c++) @(negedge clk);
    check("lvl0_samples", 32'(idx >= 40), 32'd1);
    check("lvl0_no_trig", 32'({busy, sbf}), 32'b10);
    check("lvl0_ts_kept", trig_ts, 32'd0);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("armed_rd_vld", 32'(rd_vld), 32'd0);
    check("armed_state", 32'({busy, sbf}), 32'b10);
    for (int c = 0; c < 100 && !adc_req; c++) @(negedge clk);
    check("req_seen", 32'(adc_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midhs_req", 32'(adc_req), 32'd0);
    check("midhs_state", 32'({busy, sbf}), 32'b00);
    check("midhs_adc_rst", 32'(adc_rst), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
